dmem_responder: RTL

//  Data-memory responder: the memory end of the core's load/store interface.
//  - Accepts one request at a time from the datapath over a valid/ready handshake.
//  - Serves it from an internal word RAM after a programmable wait-state count.
//  - Returns read data and an error flag over a response handshake.
//  - Replaces the zero-latency data memory so multi-cycle memories can be modelled.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dmem_ram and dmem_responder.
package dmem_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with per-byte write enable and combinational read.
// Contents are not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states.
// Optional MMIO output register enabled by DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mmio_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic accept, go_resp;

  logic              l_we;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [BE_W-1:0]   l_be;

  logic              c_we;
  logic [31:0]       c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;

  logic aligned, in_ram, mmio_hit, err;
  logic ram_we, mmio_we;
  logic [DATA_W-1:0] ram_rd, mmio_q;

  assign accept = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge itself.
  assign c_we    = (WAIT_CYCLES == 0) ? req_we    : l_we;
  assign c_addr  = (WAIT_CYCLES == 0) ? req_addr  : l_addr;
  assign c_wdata = (WAIT_CYCLES == 0) ? req_wdata : l_wdata;
  assign c_be    = (WAIT_CYCLES == 0) ? req_be    : l_be;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    go_resp = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          nxt     = RESP;
          go_resp = 1'b1;
        end else begin
          nxt = WAIT;
        end
      end
      WAIT: if (cnt == '0) begin
        nxt     = RESP;
        go_resp = 1'b1;
      end
      RESP: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= req_we;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_be    <= req_be;
    end
  end

  assign aligned = (c_addr[1:0] == 2'b00);
  assign in_ram  = (c_addr < RAM_BYTES);
`ifdef DMEM_MMIO_EN
  assign mmio_hit = aligned && (c_addr == MMIO_ADDR);
`else
  assign mmio_hit = 1'b0;
`endif
  assign err = !aligned || (!in_ram && !mmio_hit);

  assign ram_we  = go_resp && !reset && c_we && !err && !mmio_hit;
  assign mmio_we = go_resp && !reset && c_we && mmio_hit;

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .be    (c_be),
    .rdata (ram_rd)
  );

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset)        mmio_q <= '0;
    else if (mmio_we) mmio_q <= be_merge(mmio_q, c_wdata, c_be);
  end
`else
  assign mmio_q = '0;
`endif
  assign mmio_out = mmio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (go_resp) begin
      rsp_err <= err;
      if (err || c_we)   rsp_rdata <= '0;
      else if (mmio_hit) rsp_rdata <= mmio_q;
      else               rsp_rdata <= ram_rd;
    end
  end

endmodule
